rls_sequencer: RTL and testbench
================================

# rls_sequencer

Run controller for the RLS experiment datapath. It sequences the sample BRAM read address and the A/K row-select index into the RLS core. It issues one new-iteration pulse per block of M samples and captures the N coefficient writes per block into a result-RAM address stream. After B blocks it raises `final`. It replaces the free-running sample counter and the core-owned iteration index with one explicit state machine.

## Interface
- `nBits`, 32: sample/coefficient width (pass-through only, for consistency checks).
- `N`, 16: coefficients produced per block.
- `M`, 32: samples (A/K rows) per block.
- `B`, 1024: blocks per run.
- `AW`, 15: address width; elaboration error if `$clog2(M*B) > AW` or `$clog2(N*B) > AW`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- `y_addr`  out  AW  sample BRAM read address (BRAM read latency 1 cycle).
- `y_valid`  out  1  sample on BRAM `douta` is valid for the core this cycle.
- `iter`  out  32  A/K row index 0..M-1 into both row muxes; aligned with `y_valid`.
- `newit`  out  1  one-cycle pulse to the core at the start of each block.
- `x_write`  in  1  core strobe: one coefficient on `x` this cycle.
- `core_done`  in  1  core finished the current block's solution.
- `out_we`  out  1  result-RAM write enable (combinational copy of accepted `x_write`).
- `out_addr`  out  AW  result-RAM write address, blk*N + coefficient count.
- `busy`  out  1  high in any state except IDLE and DONE.
- `final`  out  1  high in DONE.
- `err`  out  1  sticky; set when a block ends with coefficient count ≠ N or a write arrives with count = N.

## Operation
- Registers: `blk` (0..B-1), `idx` (0..M-1), `xcnt` (0..N), `rd_q` (delayed read enable), `err`.
- IDLE: all outputs 0. `start` loads blk=0, idx=0, xcnt=0, clears `err`, and goes to NEWIT.
- NEWIT (1 cycle): `newit`=1, then FEED.
- FEED (M cycles): read enable=1, `y_addr`=blk*M+idx, idx++. Goes to WAIT after idx=M-1.
- Alignment: `y_valid`=`rd_q` and `iter`=idx delayed by one cycle, so both line up with BRAM data.
- WAIT: waits for `core_done`.
  - If blk=B-1, go to DONE.
  - Otherwise blk++, idx=0, xcnt=0, go to NEWIT.
- Coefficient capture, in FEED and WAIT:
  - Each `x_write` with xcnt<N gives `out_we`=1, `out_addr`=blk*N+xcnt, xcnt++.
  - `x_write` with xcnt=N is dropped (`out_we`=0) and sets `err`.
  - `x_write` in IDLE, NEWIT or DONE is ignored.
- Same-cycle `x_write` and `core_done`: the write is counted first. The N-check uses the post-increment value.
- `core_done` with final xcnt≠N sets `err`; the sequencer still advances.
- `core_done` in FEED is latched (`done_pend`) and acted on at WAIT entry.
- DONE: `final`=1 and held. `start` restarts exactly as from IDLE.
- `start` while `busy` is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `err`=0. Reset mid-run aborts immediately. No partial flush.
- Latency:
  - `start` to `newit`: 1 cycle.
  - `newit` to first `y_addr`: 1 cycle.
  - First `y_addr` to first `y_valid`: 1 cycle.
- Block cost: 1 + M cycles plus core wait. Minimum 2 + M cycles per block (`core_done` on first WAIT cycle).
- `y_valid` stays high for exactly M consecutive cycles per block. `iter` counts 0..M-1 across them.
- `out_we`/`out_addr` are combinational from `x_write` and registers. Result RAM samples them on the same edge.
- Address wrap: none. y_addr max = M*B-1 and out_addr max = N*B-1, both guaranteed by the parameter check.

## Structure
- Shared package `rls_pkg`: state enum (IDLE, NEWIT, FEED, WAIT, DONE) and the default N/M/B/AW constants, shared with the RLS top.
- One sub-module: `rls_addr_gen`. It holds blk/idx with the base-multiply, done incrementally (add M or N per block, no multiplier), producing `y_addr` and `out_addr` bases.
- Chipscope/BRAM stay in the top level.

## Test plan
Bench parameters N=2, M=4, B=3, AW=15.
- Reset then `start` with a core model (2 writes, then `core_done` 3 cycles after FEED) -> `y_addr` 0..3, 4..7, 8..11; `iter` 0..3 each block; `out_addr` 0,1,2,3,4,5; `final`=1; `err`=0.
- Check `y_valid` on the first block -> high exactly 4 cycles, one cycle after `y_addr`=0..3.
- `x_write` and `core_done` in the same cycle as the 2nd write -> advances, `out_addr`=1 written, `err`=0.
- 3 writes in block 1 -> third dropped (`out_we`=0), `err`=1 sticky through DONE; a restart clears it.
- Assert `reset` during block 1 FEED -> next cycle all outputs 0 and IDLE; a later `start` restarts at `y_addr`=0.
- `start` pulsed during WAIT -> ignored. `start` in DONE -> new run with `final` low, then `newit` after 1 cycle.

Source files
------------

// File: rtl/rls_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rls_pkg
// Description : Shared state encoding and default sizing for the RLS run.
// Revision    : 1.0 - initial release
// ============================================================================
package rls_pkg;

    localparam int c_nbits = 32;
    localparam int c_n     = 16;
    localparam int c_m     = 32;
    localparam int c_b     = 1024;
    localparam int c_aw    = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEWIT = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rls_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rls_sequencer_if
// Description : Sequencer control bus between run controller, BRAMs and core.
// Revision    : 1.0 - initial release
// ============================================================================
interface rls_sequencer_if #(
    parameter int AW = 15
) ();

    logic          start;
    logic [AW-1:0] y_addr;
    logic          y_valid;
    logic [31:0]   iter;
    logic          newit;
    logic          x_write;
    logic          core_done;
    logic          out_we;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          final_flag;
    logic          err;

    modport master (
        input  start, x_write, core_done,
        output y_addr, y_valid, iter, newit, out_we, out_addr, busy, final_flag, err
    );

    modport slave (
        output start, x_write, core_done,
        input  y_addr, y_valid, iter, newit, out_we, out_addr, busy, final_flag, err
    );

endinterface
`default_nettype wire

// File: rtl/rls_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : rls_addr_gen
// Description : Block/row counters with incrementally accumulated address bases.
// Revision    : 1.0 - initial release
// ============================================================================
module rls_addr_gen #(
    parameter int N  = 16,
    parameter int M  = 32,
    parameter int B  = 1024,
    parameter int AW = 15
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          i_clear,
    input  wire logic          i_step_idx,
    input  wire logic          i_next_blk,
    output logic [AW-1:0]      o_y_addr,
    output logic [AW-1:0]      o_out_base,
    output logic [AW-1:0]      o_idx,
    output logic               o_last_idx,
    output logic               o_last_blk
);

    logic [AW-1:0] r_blk;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_y_base;
    logic [AW-1:0] r_o_base;

    // Bases advance by M and N per block so blk*M / blk*N never need a multiplier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk    <= '0;
            r_idx    <= '0;
            r_y_base <= '0;
            r_o_base <= '0;
        end else if (i_clear) begin
            r_blk    <= '0;
            r_idx    <= '0;
            r_y_base <= '0;
            r_o_base <= '0;
        end else if (i_next_blk) begin
            r_blk    <= r_blk + 1'b1;
            r_idx    <= '0;
            r_y_base <= r_y_base + AW'(M);
            r_o_base <= r_o_base + AW'(N);
        end else if (i_step_idx) begin
            r_idx    <= r_idx + 1'b1;
        end
    end

    assign o_y_addr   = r_y_base + r_idx;
    assign o_out_base = r_o_base;
    assign o_idx      = r_idx;
    assign o_last_idx = (r_idx == AW'(M - 1));
    assign o_last_blk = (r_blk == AW'(B - 1));

endmodule
`default_nettype wire

// File: rtl/rls_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rls_sequencer
// Description : Run controller sequencing sample reads, row index, new-iteration
//               pulses and result-RAM coefficient capture for the RLS core.
// Revision    : 1.0 - initial release
// ============================================================================
module rls_sequencer
    import rls_pkg::*;
#(
    parameter int NBITS = c_nbits,
    parameter int N     = c_n,
    parameter int M     = c_m,
    parameter int B     = c_b,
    parameter int AW    = c_aw
) (
    input wire logic          clk,
    input wire logic          reset,
    rls_sequencer_if.master   bus
);

    localparam int             XW    = $clog2(N + 1);
    localparam logic [XW-1:0]  c_n_x = XW'(N);

    if (($clog2(M * B) > AW) || ($clog2(N * B) > AW) || (NBITS < 1)) begin : g_param_check
        $error("rls_sequencer: AW too small for M*B or N*B");
    end

    state_t        r_state;
    state_t        w_next;
    logic [XW-1:0] r_xcnt;
    logic [XW-1:0] w_xcnt_post;
    logic          r_done_pend;
    logic          r_rd_q;
    logic [31:0]   r_iter;
    logic          r_err;

    logic          w_clear;
    logic          w_step;
    logic          w_next_blk;
    logic          w_capture;
    logic          w_accept;
    logic          w_overrun;
    logic          w_done_now;
    logic          w_cnt_bad;

    logic [AW-1:0] w_y_addr;
    logic [AW-1:0] w_out_base;
    logic [AW-1:0] w_idx;
    logic          w_last_idx;
    logic          w_last_blk;

    rls_addr_gen #(
        .N  (N),
        .M  (M),
        .B  (B),
        .AW (AW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_step_idx (w_step),
        .i_next_blk (w_next_blk),
        .o_y_addr   (w_y_addr),
        .o_out_base (w_out_base),
        .o_idx      (w_idx),
        .o_last_idx (w_last_idx),
        .o_last_blk (w_last_blk)
    );

    // Write is counted before the block-end check when both land together
    assign w_capture   = (r_state == S_FEED) || (r_state == S_WAIT);
    assign w_accept    = w_capture && bus.x_write && (r_xcnt < c_n_x);
    assign w_overrun   = w_capture && bus.x_write && (r_xcnt == c_n_x);
    assign w_xcnt_post = r_xcnt + XW'(w_accept);
    assign w_done_now  = (r_state == S_WAIT) && (bus.core_done || r_done_pend);
    assign w_cnt_bad   = w_done_now && (w_xcnt_post != c_n_x);

    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_step     = 1'b0;
        w_next_blk = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_clear = 1'b1;
                    w_next  = S_NEWIT;
                end
            end
            S_NEWIT: w_next = S_FEED;
            S_FEED: begin
                w_step = !w_last_idx;
                if (w_last_idx) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_now) begin
                    if (w_last_blk) begin
                        w_next = S_DONE;
                    end else begin
                        w_next_blk = 1'b1;
                        w_next     = S_NEWIT;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_xcnt      <= '0;
            r_done_pend <= 1'b0;
            r_rd_q      <= 1'b0;
            r_iter      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clear || w_next_blk) begin
                r_xcnt <= '0;
            end else if (w_accept) begin
                r_xcnt <= w_xcnt_post;
            end
            if (w_clear || w_done_now) begin
                r_done_pend <= 1'b0;
            end else if ((r_state == S_FEED) && bus.core_done) begin
                r_done_pend <= 1'b1;
            end
            // Delay read enable and row index to line up with BRAM read data
            r_rd_q <= (r_state == S_FEED);
            r_iter <= (r_state == S_FEED) ? 32'(w_idx) : 32'd0;
            if (w_clear) begin
                r_err <= 1'b0;
            end else if (w_overrun || w_cnt_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.newit      = (r_state == S_NEWIT);
    assign bus.busy       = (r_state == S_NEWIT) || (r_state == S_FEED) || (r_state == S_WAIT);
    assign bus.final_flag = (r_state == S_DONE);
    assign bus.y_addr     = (r_state == S_FEED) ? w_y_addr : '0;
    assign bus.y_valid    = r_rd_q;
    assign bus.iter       = r_iter;
    assign bus.out_we     = w_accept;
    assign bus.out_addr   = w_accept ? (w_out_base + AW'(r_xcnt)) : '0;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rls_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rls_sequencer
// Description : Directed self-checking bench for rls_sequencer (N=2, M=4, B=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rls_sequencer;

    localparam int c_aw = 15;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    rls_sequencer_if #(.AW(c_aw)) bus ();

    rls_sequencer #(
        .NBITS (32),
        .N     (2),
        .M     (4),
        .B     (3),
        .AW    (c_aw)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},   32'(bus.busy),       0);
        chk({tag, "_final"},  32'(bus.final_flag), 0);
        chk({tag, "_newit"},  32'(bus.newit),      0);
        chk({tag, "_yvalid"}, 32'(bus.y_valid),    0);
        chk({tag, "_yaddr"},  32'(bus.y_addr),     0);
        chk({tag, "_iter"},   bus.iter,            0);
        chk({tag, "_err"},    32'(bus.err),        0);
        chk({tag, "_we"},     32'(bus.out_we),     0);
    endtask

    // Entered in NEWIT; leaves the sequencer in the first WAIT cycle
    task automatic feed_block(input int blk);
        chk("newit_pulse", 32'(bus.newit),   1);
        chk("newit_busy",  32'(bus.busy),    1);
        chk("newit_yv",    32'(bus.y_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("feed_yaddr", 32'(bus.y_addr),  32'(blk * 4 + i));
            chk("feed_newit", 32'(bus.newit),   0);
            chk("feed_yv",    32'(bus.y_valid), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("feed_iter", bus.iter, 32'(i - 1));
        end
        tick();
        chk("wait_yv",    32'(bus.y_valid), 1);
        chk("wait_iter",  bus.iter,         3);
        chk("wait_yaddr", 32'(bus.y_addr),  0);
        chk("wait_busy",  32'(bus.busy),    1);
    endtask

    task automatic write(input bit exp_we, input int exp_addr);
        bus.x_write = 1'b1;
        #1;
        chk("out_we", 32'(bus.out_we), 32'(exp_we));
        if (exp_we) chk("out_addr", 32'(bus.out_addr), 32'(exp_addr));
        tick();
        bus.x_write = 1'b0;
    endtask

    task automatic finish_block();
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.x_write   = 1'b0;
        bus.core_done = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("idle");

        // Run 1: nominal core, two writes then core_done per block
        pulse_start();
        for (int b = 0; b < 3; b++) begin
            feed_block(b);
            write(1'b1, b * 2);
            chk("wait2_yv", 32'(bus.y_valid), 0);
            write(1'b1, b * 2 + 1);
            finish_block();
        end
        chk("run1_final", 32'(bus.final_flag), 1);
        chk("run1_busy",  32'(bus.busy),       0);
        chk("run1_err",   32'(bus.err),        0);
        tick();
        chk("run1_final_hold", 32'(bus.final_flag), 1);
        write(1'b0, 0);
        chk("done_write_err", 32'(bus.err), 0);

        // Run 2: restart from DONE, same-cycle write/done, overrun, start in WAIT
        pulse_start();
        chk("restart_final", 32'(bus.final_flag), 0);
        feed_block(0);
        write(1'b1, 0);
        bus.x_write   = 1'b1;
        bus.core_done = 1'b1;
        #1;
        chk("same_we",   32'(bus.out_we),   1);
        chk("same_addr", 32'(bus.out_addr), 1);
        tick();
        bus.x_write   = 1'b0;
        bus.core_done = 1'b0;
        chk("same_err", 32'(bus.err), 0);
        feed_block(1);
        write(1'b1, 2);
        write(1'b1, 3);
        chk("pre_ovr_err", 32'(bus.err), 0);
        write(1'b0, 0);
        chk("ovr_err", 32'(bus.err), 1);
        finish_block();
        chk("ovr_err_sticky", 32'(bus.err), 1);
        feed_block(2);
        pulse_start();
        chk("wstart_newit", 32'(bus.newit),      0);
        chk("wstart_busy",  32'(bus.busy),       1);
        chk("wstart_final", 32'(bus.final_flag), 0);
        write(1'b1, 4);
        write(1'b1, 5);
        finish_block();
        chk("run2_final", 32'(bus.final_flag), 1);
        chk("run2_err",   32'(bus.err),        1);

        // Run 3: restart clears err, then reset during block 1 FEED
        pulse_start();
        chk("run3_err_clr", 32'(bus.err), 0);
        feed_block(0);
        write(1'b1, 0);
        write(1'b1, 1);
        finish_block();
        chk("b1_newit", 32'(bus.newit), 1);
        tick();
        chk("b1_yaddr0", 32'(bus.y_addr), 4);
        tick();
        chk("b1_yaddr1", 32'(bus.y_addr), 5);
        reset = 1'b1;
        #1;
        chk_idle("abort");
        tick();
        reset = 1'b0;
        tick();
        chk_idle("post_abort");
        pulse_start();
        feed_block(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
